// File: rtl/riscv_v_elastic_pipe.sv
// riscv_v_elastic_pipe
//   Valid/ready pipeline of NUM_STAGES register slices. Every slice has its
//   own valid bit, so a stalled consumer lets entries close up into empty
//   slices ahead of them before the producer is blocked. NUM_STAGES=0
//   degenerates to a combinational pass-through.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   en               global advance enable (0 freezes every register)
//   flush            synchronous kill of all in-flight entries
//   in_valid/in_ready/in_data     producer handshake and payload
//   out_valid/out_ready/out_data  consumer handshake and payload
//   stage_valid      per-slice valid bits, bit 0 = input-side slice
//   occupancy        number of valid slices (registered counter)
module riscv_v_elastic_pipe #(
  parameter int                DATA_W     = 32,
  parameter int                NUM_STAGES = 2,
  parameter int                CNT_W      = (NUM_STAGES == 0) ? 1 : $clog2(NUM_STAGES + 1),
  parameter logic [DATA_W-1:0] RST_DATA   = '0,
  localparam int               SV_W       = (NUM_STAGES == 0) ? 1 : NUM_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SV_W-1:0]   stage_valid,
  output logic [CNT_W-1:0]  occupancy
);

  if (NUM_STAGES == 0) begin : g_pass
    // No storage: clock and reset have nothing to drive.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign out_valid   = in_valid & en & ~flush;
    assign in_ready    = out_ready & en & ~flush;
    assign out_data    = in_data;
    assign stage_valid = '0;
    assign occupancy   = '0;

  end else begin : g_pipe
    // Index k holds slice k+1; index NUM_STAGES-1 drives the output.
    logic [NUM_STAGES-1:0] v_q, v_d;
    logic [NUM_STAGES-1:0] rdy;
    logic [DATA_W-1:0]     d_q [NUM_STAGES];
    logic [DATA_W-1:0]     d_d [NUM_STAGES];
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  adv;
    logic                  in_hs;
    logic                  out_hs;

    // A slice can take new content when it is empty or everything downstream
    // of it can move. Built from the output side so the chain stays a plain
    // ripple of OR gates from out_ready to in_ready.
    always_comb begin : ready_chain
      logic r;
      rdy = '0;
      r   = out_ready;
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        r      = ~v_q[k] | r;
        rdy[k] = r;
      end
    end

    assign adv       = en & ~flush;
    assign in_ready  = rdy[0] & adv;
    assign out_valid = v_q[NUM_STAGES-1] & adv;
    assign out_data  = d_q[NUM_STAGES-1];
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;

    // Slice advance: valid always follows the upstream slice when allowed to
    // move, data only when upstream is valid so empty slices keep stale data.
    always_comb begin : next_state
      v_d = v_q;
      for (int k = 0; k < NUM_STAGES; k++) begin
        d_d[k] = d_q[k];
      end
      if (adv) begin
        if (rdy[0]) begin
          v_d[0] = in_valid;
          if (in_valid) begin
            d_d[0] = in_data;
          end
        end
        for (int k = 1; k < NUM_STAGES; k++) begin
          if (rdy[k]) begin
            v_d[k] = v_q[k-1];
            if (v_q[k-1]) begin
              d_d[k] = d_q[k-1];
            end
          end
        end
      end
      if (flush) begin
        v_d = '0;
      end
    end

    // Occupancy tracks handshakes rather than re-counting valid bits.
    always_comb begin : next_count
      cnt_d = cnt_q;
      if (flush) begin
        cnt_d = '0;
      end else if (in_hs && !out_hs) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (out_hs && !in_hs) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= '0;
        cnt_q <= '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
          d_q[k] <= RST_DATA;
        end
      end else begin
        v_q   <= v_d;
        cnt_q <= cnt_d;
        for (int k = 0; k < NUM_STAGES; k++) begin
          d_q[k] <= d_d[k];
        end
      end
    end

    assign stage_valid = v_q;
    assign occupancy   = cnt_q;
  end

endmodule

// File: tb/tb_riscv_v_elastic_pipe.sv
// Bench for riscv_v_elastic_pipe: a 3-slice instance driven by directed and
// random stimulus with a queue-based reference, plus a pass-through instance.
module tb_riscv_v_elastic_pipe;
  localparam int W = 32;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 3-slice instance
  logic         rst_n, en, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [N-1:0] stage_valid;
  logic [1:0]   occupancy;

  // pass-through instance
  logic         p_en, p_flush, p_in_valid, p_out_ready;
  logic [W-1:0] p_in_data;
  logic         p_in_ready, p_out_valid;
  logic [W-1:0] p_out_data;
  logic [0:0]   p_stage_valid;
  logic [0:0]   p_occupancy;

  riscv_v_elastic_pipe #(.DATA_W(W), .NUM_STAGES(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stage_valid(stage_valid), .occupancy(occupancy)
  );

  riscv_v_elastic_pipe #(.DATA_W(W), .NUM_STAGES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(p_en), .flush(p_flush),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data),
    .stage_valid(p_stage_valid), .occupancy(p_occupancy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the pipe is an ordered FIFO of at most N entries.
  logic [W-1:0] exp_q[$];
  int           m_sz;
  logic         m_rdy;
  logic         acc;

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: checks the DUT against the FIFO model every cycle, pops on
  // output handshakes, records accepted inputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_occupancy", occupancy, 0);
      chk("rst_stage_valid", stage_valid, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, en && !flush);
      exp_q.delete();
    end else begin
      m_sz = exp_q.size();
      chk("occupancy", occupancy, m_sz);
      chk("stage_valid_popcount", $countones(stage_valid), m_sz);
      m_rdy = en && !flush && (out_ready || m_sz < N);
      chk("in_ready", in_ready, m_rdy);
      if (!(en && !flush) || m_sz == 0)
        chk("out_valid_gated", out_valid, 0);
      if (out_valid && out_ready && m_sz > 0)
        chk("out_data", out_data, exp_q.pop_front());
      if (flush)
        exp_q.delete();
      else if (in_valid && in_ready)
        exp_q.push_back(in_data);
    end
  end

  task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy,
                      input logic e = 1'b1, input logic f = 1'b0);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    en        = e;
    flush     = f;
    @(negedge clk);
    #1;
    acc = in_valid && in_ready;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      step(1'b0, '0, 1'b1);
      if (exp_q.size() == 0) break;
    end
    chk("drain_empty", exp_q.size(), 0);
    step(1'b0, '0, 1'b1);
    chk("drain_occupancy", occupancy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  logic [W-1:0] nd, od_s;
  int           na, ne;
  logic [N-1:0] sv_s;
  logic [1:0]   oc_s;
  logic         r_iv, r_or, r_en, r_fl;

  initial begin
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    p_en = 1'b1; p_flush = 1'b0; p_in_valid = 1'b0; p_out_ready = 1'b0; p_in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Streaming: latency N cycles, one per cycle, occupancy holds at N
    nd = 1;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, nd, 1'b1);
      chk("stream_in_ready", in_ready, 1);
      chk("stream_out_valid", out_valid, c >= N);
      if (c >= N) chk("stream_occupancy", occupancy, N);
      if (acc) nd = nd + 1;
    end
    drain();

    // Bubble collapse with the consumer stalled
    step(1'b1, 32'hA, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, 32'hB, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("bubble_stage_valid", stage_valid, 3'b110);
    chk("bubble_occupancy", occupancy, 2);
    chk("bubble_in_ready", in_ready, 1);
    step(1'b1, 32'hC, 1'b0);
    chk("bubble_accept_c", acc, 1);
    step(1'b1, 32'hD, 1'b0);
    chk("full_in_ready", in_ready, 0);

    // Full pipe with simultaneous accept and emit
    na = 0; ne = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'hD + i, 1'b1);
      if (acc) na++;
      if (out_valid && out_ready) ne++;
      chk("simul_occupancy", occupancy, N);
    end
    chk("simul_accepts", na, 5);
    chk("simul_emits", ne, 5);
    drain();

    // Flush with two entries in flight and an input offered
    step(1'b1, 32'h100, 1'b0);
    step(1'b1, 32'h101, 1'b0);
    step(1'b1, 32'h102, 1'b0, 1'b1, 1'b1);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 0);
    step(1'b0, '0, 1'b0);
    chk("flush_occupancy", occupancy, 0);
    chk("flush_stage_valid", stage_valid, 0);
    step(1'b1, 32'h200, 1'b1);
    step(1'b1, 32'h201, 1'b1);
    drain();

    // Enable low for 4 cycles mid-stream
    step(1'b1, 32'h300, 1'b0);
    step(1'b1, 32'h301, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h3FF, 1'b1, 1'b0);
      chk("en_out_valid", out_valid, 0);
      chk("en_in_ready", in_ready, 0);
      if (i == 0) begin
        sv_s = stage_valid; oc_s = occupancy; od_s = out_data;
      end else begin
        chk("en_frozen_sv", stage_valid, sv_s);
        chk("en_frozen_occ", occupancy, oc_s);
        chk("en_frozen_data", out_data, od_s);
      end
    end
    step(1'b1, 32'h302, 1'b1);
    step(1'b1, 32'h303, 1'b1);
    drain();

    // Asynchronous reset in the middle of a cycle
    step(1'b1, 32'h400, 1'b0);
    step(1'b1, 32'h401, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("arst_stage_valid", stage_valid, 0);
    chk("arst_occupancy", occupancy, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, 32'h500, 1'b1);
    step(1'b1, 32'h501, 1'b1);
    drain();

    // Random traffic against the FIFO model
    for (int i = 0; i < 400; i++) begin
      r_iv = 1'($urandom_range(0, 1));
      r_or = ($urandom_range(0, 3) != 0);
      r_en = ($urandom_range(0, 9) != 0);
      r_fl = ($urandom_range(0, 29) == 0);
      step(r_iv, $urandom, r_or, r_en, r_fl);
    end
    step(1'b0, '0, 1'b1);
    drain();

    // Pass-through instance
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      p_in_valid  = 1'($urandom_range(0, 1));
      p_out_ready = 1'($urandom_range(0, 1));
      p_in_data   = $urandom;
      p_en        = (i % 5 != 4);
      p_flush     = (i % 4 == 3);
      @(negedge clk);
      chk("pt_out_data", p_out_data, p_in_data);
      chk("pt_out_valid", p_out_valid, p_in_valid && p_en && !p_flush);
      chk("pt_in_ready", p_in_ready, p_out_ready && p_en && !p_flush);
      chk("pt_occupancy", p_occupancy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_v_elastic_pipe.md
# riscv_v_elastic_pipe

Parametrised valid/ready pipeline of NUM_STAGES register slices with bubble collapsing, global enable, synchronous flush and an occupancy count. It is the drop-in replacement for the fixed-shift stage block on vector-unit paths that need backpressure. Typical placements are between decode and the vector register-file read, and on the lane writeback return path. Every stage carries its own valid bit, so a stalled consumer squeezes bubbles out before it blocks the producer.

## Interface
- DATA_W, 32, payload width in bits (>=1)
- NUM_STAGES, 2, number of register slices (>=0; 0 = combinational pass-through)
- CNT_W, $clog2(NUM_STAGES+1) (min 1), occupancy counter width
- RST_DATA, '0, value loaded into every data register on reset
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  global advance enable; 0 freezes the pipe
- flush  in  1  synchronous kill of all in-flight entries
- in_valid  in  1  producer has data
- in_ready  out  1  pipe accepts in_data this cycle
- in_data  in  DATA_W  producer payload
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts this cycle
- out_data  out  DATA_W  payload from the last stage
- stage_valid  out  max(NUM_STAGES,1)  valid bit per stage; bit 0 is the input-side stage (0 when NUM_STAGES=0)
- occupancy  out  CNT_W  number of valid stages

## Operation
- Stages are indexed 1..NUM_STAGES. Each stage holds v[i] and d[i]. Stage NUM_STAGES drives the output.
- Internal readiness chain: rdy[NUM_STAGES+1] = out_ready; rdy[i] = !v[i] || rdy[i+1]. It is combinational, so the out_ready -> in_ready path has depth NUM_STAGES.
- in_ready = rdy[1] & en & !flush.
- out_valid = v[NUM_STAGES] & en & !flush. out_data = d[NUM_STAGES].
- Advance condition for stage i: move[i] = en & !flush & rdy[i].
  - When move[i] is set, v[i] <= v[i-1] and d[i] <= d[i-1], where stage 0 is (in_valid, in_data).
  - d[i] updates only when v[i-1]=1. An empty stage keeps its stale data.
- Bubble collapse: a valid entry advances into an empty downstream stage even while out_ready=0.
- Flush takes priority over en and the handshake:
  - All v[i] <= 0. Data registers are unchanged.
  - The input is not accepted and no output handshake occurs in that cycle.
- en=0: all registers hold, in_ready=0, out_valid=0.
- occupancy = popcount of v[]. It is a registered counter:
  - +1 on an input handshake, -1 on an output handshake, unchanged when both or neither occur.
  - Forced to 0 on flush.
  - It must always equal popcount(stage_valid).
- NUM_STAGES=0 (pass-through):
  - out_valid = in_valid & en & !flush; in_ready = out_ready & en & !flush; out_data = in_data.
  - occupancy = 0.
- Entries are never dropped except by flush, never duplicated, and never reordered.

## Timing
- Reset (rst_n=0, asynchronous): v[] = 0, d[] = RST_DATA, occupancy = 0, out_valid = 0. in_ready = out_ready-driven chain result & en & !flush, i.e. 1 when en=1 and flush=0.
- Deassertion of rst_n is synchronous to clk, handled by the upstream synchronizer. The first handshake is allowed on the first edge after release.
- Latency: an entry accepted at edge N appears with out_valid=1 after edge N+NUM_STAGES, provided out_ready was never 0 on the way.
- Throughput: 1 entry per cycle at full occupancy with out_ready held at 1.
- Full: occupancy=NUM_STAGES and out_ready=0 gives in_ready=0. If out_ready=1 in the same cycle, in_ready=1 and the pipe accepts and emits in that cycle (simultaneous handshake).
- Flush in cycle N: stage_valid=0 and occupancy=0 after edge N. An input presented in cycle N is lost; the producer sees in_ready=0. in_ready can be 1 again in cycle N+1.
- Reset asserted mid-stream: all entries are discarded immediately, with no dependence on the clock.

## Test plan
- Streaming: NUM_STAGES=3, DATA_W=32, in_valid=1, out_ready=1, data 1,2,3,...
  - out_valid first rises 3 cycles after the first accept.
  - Outputs arrive in order 1,2,3,... one per cycle; occupancy holds at 3.
- Bubble collapse: push A, idle one cycle, push B, with out_ready=0.
  - After 4 cycles stage_valid=3'b110 (in bit order 1..3, i.e. A in stage 3, B in stage 2).
  - occupancy=2 and in_ready=1.
  - Filling a third entry C gives in_ready=0.
- Full and simultaneous: with the pipe full and out_ready=0, then out_ready=1 and in_valid=1 for 5 cycles.
  - Exactly 5 accepts and 5 emits.
  - occupancy stays at 3 throughout.
- Flush: with 2 entries in flight, assert flush together with in_valid=1 for one cycle.
  - out_valid=0 and in_ready=0 in the flush cycle.
  - Next cycle: occupancy=0 and stage_valid=0.
  - The flushed entries never appear at the output.
- Enable and reset: with en=0 for 4 cycles, mid-stream.
  - Registers frozen, out_valid=0, in_ready=0; the stream resumes intact when en returns to 1.
  - Then assert rst_n=0 mid-cycle: stage_valid=0 and occupancy=0 before the next edge.
- Pass-through: NUM_STAGES=0.
  - out_data equals in_data in the same cycle.
  - in_ready equals out_ready; flush=1 forces both valid and ready to 0.
